// File: rtl/mem_req_ctrl.sv
// Request/response controller between the pipeline MEM/fetch stage and mem_system.
// Optional hit/miss statistics are enabled by defining MEM_REQ_STATS_EN.
module mem_req_ctrl #(
  parameter int TIMEOUT = 63,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_data,
  output logic              resp_valid,
  output logic [15:0]       resp_data,
  output logic              resp_err,
  output logic              pipe_stall,
  output logic              ms_Rd,
  output logic              ms_Wr,
  output logic [15:0]       ms_Addr,
  output logic [15:0]       ms_DataIn,
  input  logic [15:0]       ms_DataOut,
  input  logic              ms_Done,
  input  logic              ms_Stall,
  input  logic              ms_CacheHit,
`ifdef MEM_REQ_STATS_EN
  input  logic              ms_err,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
`else
  input  logic              ms_err
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [5:0] TMO = TIMEOUT[5:0];

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_lat_rd;
  logic        r_lat_wr;
  logic [15:0] r_lat_addr;
  logic [15:0] r_lat_data;
  logic [5:0]  r_wdog;

  logic w_req_any;
  logic w_legal;
  logic w_illegal;
  logic w_wdog_hit;
  logic w_start;

  assign w_req_any  = req_rd | req_wr;
  assign w_legal    = (req_rd ^ req_wr) & ~req_addr[0];
  assign w_illegal  = w_req_any & ~w_legal;
  assign w_wdog_hit = (r_wdog == TMO);
  assign w_start    = (r_state == S_IDLE) && (w_state_nxt == S_BUSY);

  // State register, request latch and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lat_rd   <= 1'b0;
      r_lat_wr   <= 1'b0;
      r_lat_addr <= '0;
      r_lat_data <= '0;
      r_wdog     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_lat_rd   <= req_rd;
        r_lat_wr   <= req_wr;
        r_lat_addr <= req_addr;
        r_lat_data <= req_data;
        r_wdog     <= '0;
      end else if ((r_state == S_BUSY) && !w_wdog_hit) begin
        r_wdog <= r_wdog + 6'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_legal && !ms_err && !ms_Done) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (ms_err || ms_Done || w_wdog_hit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  always_comb begin
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    pipe_stall = 1'b0;
    ms_Rd      = 1'b0;
    ms_Wr      = 1'b0;
    ms_Addr    = '0;
    ms_DataIn  = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_illegal) begin
            resp_err = 1'b1;
          end else if (w_legal) begin
            ms_Rd     = req_rd;
            ms_Wr     = req_wr;
            ms_Addr   = req_addr;
            ms_DataIn = req_data;
            if (ms_err) begin
              resp_err = 1'b1;
            end else if (ms_Done) begin
              resp_valid = 1'b1;
              resp_data  = req_rd ? ms_DataOut : 16'h0000;
            end else begin
              pipe_stall = 1'b1;
            end
          end
        end
        S_BUSY: begin
          ms_Rd     = r_lat_rd;
          ms_Wr     = r_lat_wr;
          ms_Addr   = r_lat_addr;
          ms_DataIn = r_lat_data;
          if (ms_err) begin
            resp_err = 1'b1;
          end else if (ms_Done) begin
            resp_valid = 1'b1;
            resp_data  = r_lat_rd ? ms_DataOut : 16'h0000;
          end else if (w_wdog_hit) begin
            resp_err = 1'b1;
          end else begin
            pipe_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_REQ_STATS_EN
  logic [STAT_W-1:0] r_hit_cnt;
  logic [STAT_W-1:0] r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (resp_valid) begin
      if (ms_CacheHit) r_hit_cnt  <= r_hit_cnt + 1'b1;
      else             r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

  // ms_Stall has no control role; observed here only for debug coverage.
  cover property (@(posedge clk) disable iff (rst) (r_state == S_BUSY) && ms_Stall);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl.
// Statistics checks compile only when MEM_REQ_STATS_EN is defined (counters use STAT_W=4).
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [15:0] req_addr, req_data;
  logic        resp_valid, resp_err, pipe_stall;
  logic [15:0] resp_data;
  logic        ms_Rd, ms_Wr;
  logic [15:0] ms_Addr, ms_DataIn, ms_DataOut;
  logic        ms_Done, ms_Stall, ms_CacheHit, ms_err;
`ifdef MEM_REQ_STATS_EN
  logic [3:0]  hit_cnt, miss_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef MEM_REQ_STATS_EN
  mem_req_ctrl #(.TIMEOUT(63), .STAT_W(4)) dut (
`else
  mem_req_ctrl #(.TIMEOUT(63)) dut (
`endif
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .pipe_stall(pipe_stall),
    .ms_Rd(ms_Rd), .ms_Wr(ms_Wr), .ms_Addr(ms_Addr), .ms_DataIn(ms_DataIn),
    .ms_DataOut(ms_DataOut), .ms_Done(ms_Done), .ms_Stall(ms_Stall),
    .ms_CacheHit(ms_CacheHit),
`ifdef MEM_REQ_STATS_EN
    .ms_err(ms_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`else
    .ms_err(ms_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_rd = 0; req_wr = 0; req_addr = '0; req_data = '0;
    ms_DataOut = '0; ms_Done = 0; ms_Stall = 0; ms_CacheHit = 0; ms_err = 0;
  endtask

  // One zero-latency access completing in the request cycle.
  task automatic quick_rd(input logic hit);
    req_rd = 1; req_addr = 16'h0020; ms_Done = 1; ms_CacheHit = hit; ms_DataOut = 16'h0055;
    cyc();
    idle_inputs();
  endtask

  int stall_n, vld_n, first_err;

  initial begin
    idle_inputs();
    rst = 1;
    // Reset: outputs low even with an active, completing request on the inputs
    req_rd = 1; req_addr = 16'h0010; ms_Done = 1; ms_DataOut = 16'hBEEF;
    #12;
    chk("rst_ms_rd", ms_Rd, 0);
    chk("rst_ms_addr", ms_Addr, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_state", dut.r_state, 0);
`ifdef MEM_REQ_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
`endif
    idle_inputs();
    cyc();
    rst = 0;
    cyc();

    // Load hit, zero-cycle response
    req_rd = 1; req_addr = 16'h0010; ms_Done = 1; ms_CacheHit = 1; ms_DataOut = 16'hBEEF;
    #2;
    chk("hit_ms_rd", ms_Rd, 1);
    chk("hit_ms_addr", ms_Addr, 16'h0010);
    chk("hit_valid", resp_valid, 1);
    chk("hit_data", resp_data, 16'hBEEF);
    chk("hit_stall", pipe_stall, 0);
    cyc();
    chk("hit_state", dut.r_state, 0);
    idle_inputs();
    #2;
    chk("idle_valid", resp_valid, 0);

    // Store miss: 12 stalled cycles, request inputs disturbed while BUSY
    cyc();
    stall_n = 0; vld_n = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i == 0) begin
        req_wr = 1; req_addr = 16'h0400; req_data = 16'h1234;
      end else begin
        req_addr = 16'hFFFE; req_data = 16'h0000;
      end
      ms_Done = (i == 12);
      #2;
      chk("miss_ms_addr", ms_Addr, 16'h0400);
      chk("miss_ms_din", ms_DataIn, 16'h1234);
      stall_n += int'(pipe_stall);
      vld_n   += int'(resp_valid);
      if (i == 12) begin
        chk("miss_done_valid", resp_valid, 1);
        chk("miss_done_stall", pipe_stall, 0);
      end
      cyc();
    end
    idle_inputs();
    #2;
    chk("miss_stall_cycles", stall_n, 12);
    chk("miss_valid_count", vld_n, 1);
    chk("miss_after_wr", ms_Wr, 0);
    chk("miss_after_valid", resp_valid, 0);
    cyc();

    // Illegal requests
    req_rd = 1; req_wr = 1; req_addr = 16'h0008;
    #2;
    chk("ill_rdwr_err", resp_err, 1);
    chk("ill_rdwr_ms_rd", ms_Rd, 0);
    chk("ill_rdwr_ms_wr", ms_Wr, 0);
    chk("ill_rdwr_stall", pipe_stall, 0);
    cyc();
    req_wr = 0; req_addr = 16'h0003;
    #2;
    chk("ill_odd_err", resp_err, 1);
    chk("ill_odd_ms_rd", ms_Rd, 0);
    cyc();
    chk("ill_state", dut.r_state, 0);
    idle_inputs();
    #2;
    chk("ill_err_clear", resp_err, 0);
    cyc();

    // ms_err on the third BUSY cycle, together with Done (error wins)
    req_rd = 1; req_addr = 16'h0020;
    #2;
    chk("merr_req_stall", pipe_stall, 1);
    cyc();
    cyc();
    cyc();
    ms_err = 1; ms_Done = 1; ms_DataOut = 16'h7777;
    #2;
    chk("merr_err", resp_err, 1);
    chk("merr_valid", resp_valid, 0);
    chk("merr_stall", pipe_stall, 0);
    cyc();
    idle_inputs();
    #2;
    chk("merr_state", dut.r_state, 0);
    chk("merr_ms_rd", ms_Rd, 0);
    chk("merr_err_clear", resp_err, 0);
    cyc();

    // Watchdog: first BUSY cycle has wdog=0, error when wdog reaches 63
    req_rd = 1; req_addr = 16'h0040;
    #2;
    chk("wd_req_stall", pipe_stall, 1);
    cyc();
    first_err = -1;
    for (int k = 0; k <= 63; k++) begin
      #2;
      if (resp_err && first_err < 0) first_err = k;
      if (k == 63) chk("wd_stall_release", pipe_stall, 0);
      cyc();
    end
    chk("wd_first_err", first_err, 63);
    idle_inputs();
    #2;
    chk("wd_state", dut.r_state, 0);
    cyc();

    // Reset in the middle of a BUSY store: immediate abort, no response
    req_wr = 1; req_addr = 16'h0100; req_data = 16'hA5A5;
    cyc();
    cyc();
    #1;
    rst = 1;
    #1;
    chk("rmid_ms_wr", ms_Wr, 0);
    chk("rmid_stall", pipe_stall, 0);
    chk("rmid_state", dut.r_state, 0);
    cyc();
    idle_inputs();
    ms_Done = 1;
    rst = 0;
    vld_n = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      vld_n += int'(resp_valid) + int'(resp_err) + int'(ms_Wr);
      cyc();
    end
    chk("rmid_no_resp", vld_n, 0);
    idle_inputs();
    cyc();

`ifdef MEM_REQ_STATS_EN
    // Counters were cleared by the reset above
    quick_rd(1); quick_rd(0); quick_rd(1); quick_rd(0); quick_rd(1);
    #2;
    chk("stat_hit", hit_cnt, 3);
    chk("stat_miss", miss_cnt, 2);
    for (int k = 0; k < 13; k++) quick_rd(1);
    #2;
    chk("stat_hit_wrap", hit_cnt, 0);
    chk("stat_miss_hold", miss_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
